// File: rtl/prog_mem_responder.sv
// prog_mem_responder: program memory for the instruction-fetch core.
// Serves a registered instruction word one cycle after the fetch address and
// is loaded through a byte-serial framed loader (sync, length, words, XOR sum).
// While a load runs, or the image is not verified, the core is held and fed NOPs.
// Optional feature macro: PROG_MEM_PARITY_EN (per-word even parity with a
// sticky read-parity error flag).
module prog_mem_responder #(
  parameter int ADR_W = 4,
  parameter int DAT_W = 14
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [ADR_W-1:0] prog_adr_i,
  output logic [DAT_W-1:0] prog_dat_o,
  output logic             core_hold_o,
  input  logic [7:0]       ld_byte_i,
  input  logic             ld_valid_i,
  output logic             ld_ready_o,
  output logic             mem_valid_o,
  output logic             load_ok_o,
  output logic             load_err_o,
  output logic             parity_err_o
);

  localparam int         DEPTH     = 1 << ADR_W;
  localparam logic [8:0] DEPTH9    = 9'(DEPTH);
  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  typedef enum logic [2:0] {S_SYNC, S_LEN, S_LO, S_HI, S_WR, S_SUM} state_t;

  // A zero length byte means a full 256-word image only when the memory is that deep.
  function automatic logic [8:0] len_decode(input logic [7:0] b);
    if (b == 8'd0 && ADR_W == 8) return 9'd256;
    else return {1'b0, b};
  endfunction

  state_t           state_q, state_n;
  logic [ADR_W:0]   ptr_q, ptr_n;
  logic [ADR_W:0]   len_q;
  logic [7:0]       lo_q;
  logic [DAT_W-9:0] hi_q;
  logic [7:0]       acc_q, acc_n;
  logic             mem_valid_q, mem_valid_n;
  logic             ok_q, ok_n;
  logic             err_q, err_n;
  logic             wr_en;
  logic             xfer;
  logic             serve;
  logic [8:0]       len_dec;
  logic [DAT_W-1:0] wr_word;
  logic [DAT_W-1:0] prog_dat_p0;

  logic [DAT_W-1:0] mem [DEPTH];

  assign xfer        = ld_valid_i & ld_ready_o;
  assign ld_ready_o  = (state_q != S_WR);
  assign core_hold_o = ~mem_valid_q | (state_q != S_SYNC);
  assign serve       = mem_valid_q & (state_q == S_SYNC);
  assign len_dec     = len_decode(ld_byte_i);
  assign wr_word     = {hi_q, lo_q};
  assign mem_valid_o = mem_valid_q;
  assign load_ok_o   = ok_q;
  assign load_err_o  = err_q;
  assign prog_dat_o  = prog_dat_p0;

  // Control state register; loader datapath bytes are not reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_SYNC;
      ptr_q       <= '0;
      acc_q       <= '0;
      mem_valid_q <= 1'b0;
      ok_q        <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_n;
      ptr_q       <= ptr_n;
      acc_q       <= acc_n;
      mem_valid_q <= mem_valid_n;
      ok_q        <= ok_n;
      err_q       <= err_n;
    end
  end

  // Next-state, checksum and pulse generation for the frame parser.
  always_comb begin
    state_n     = state_q;
    ptr_n       = ptr_q;
    acc_n       = acc_q;
    mem_valid_n = mem_valid_q;
    ok_n        = 1'b0;
    err_n       = 1'b0;
    wr_en       = 1'b0;
    case (state_q)
      S_SYNC: begin
        if (xfer && ld_byte_i == SYNC_BYTE) begin
          state_n     = S_LEN;
          mem_valid_n = 1'b0;
          acc_n       = '0;
        end
      end
      S_LEN: begin
        if (xfer) begin
          if (len_dec == 9'd0 || len_dec > DEPTH9) begin
            err_n   = 1'b1;
            state_n = S_SYNC;
          end else begin
            ptr_n   = '0;
            state_n = S_LO;
          end
        end
      end
      S_LO: begin
        if (xfer) begin
          acc_n   = acc_q ^ ld_byte_i;
          state_n = S_HI;
        end
      end
      S_HI: begin
        if (xfer) begin
          acc_n   = acc_q ^ ld_byte_i;
          state_n = S_WR;
        end
      end
      S_WR: begin
        wr_en   = 1'b1;
        ptr_n   = ptr_q + (ADR_W+1)'(1);
        state_n = (ptr_n < len_q) ? S_LO : S_SUM;
      end
      S_SUM: begin
        if (xfer) begin
          if (ld_byte_i == acc_q) begin
            mem_valid_n = 1'b1;
            ok_n        = 1'b1;
          end else begin
            err_n = 1'b1;
          end
          state_n = S_SYNC;
        end
      end
      default: state_n = S_SYNC;
    endcase
  end

  // Capture length and word bytes as they are transferred.
  always_ff @(posedge clk_i) begin
    if (xfer && state_q == S_LEN) len_q <= len_dec[ADR_W:0];
    if (xfer && state_q == S_LO)  lo_q  <= ld_byte_i;
    if (xfer && state_q == S_HI)  hi_q  <= ld_byte_i[DAT_W-9:0];
  end

  // Word write during the single WR cycle; the array itself is never reset.
  always_ff @(posedge clk_i) begin
    if (wr_en) mem[ptr_q[ADR_W-1:0]] <= wr_word;
  end

  // Fetch stage boundary: registered word, forced NOP when not serving.
  always_ff @(posedge clk_i) begin
    if (rst_i)      prog_dat_p0 <= '0;
    else if (serve) prog_dat_p0 <= mem[prog_adr_i];
    else            prog_dat_p0 <= '0;
  end

`ifdef PROG_MEM_PARITY_EN
  logic par_mem [DEPTH];
  logic par_err_q;

  // Even-parity bit stored next to each word.
  always_ff @(posedge clk_i) begin
    if (wr_en) par_mem[ptr_q[ADR_W-1:0]] <= ^wr_word;
  end

  // Sticky parity error, checked on every served fetch; a fresh error wins over the clear.
  always_ff @(posedge clk_i) begin
    if (rst_i)
      par_err_q <= 1'b0;
    else if (serve && ((^mem[prog_adr_i]) != par_mem[prog_adr_i]))
      par_err_q <= 1'b1;
    else if (ok_q)
      par_err_q <= 1'b0;
  end

  assign parity_err_o = par_err_q;
`else
  assign parity_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_prog_mem_responder.sv
// Directed testbench for prog_mem_responder (ADR_W = 4, DAT_W = 14).
module tb_prog_mem_responder;

  localparam int ADR_W = 4;
  localparam int DAT_W = 14;

  logic             clk = 1'b0;
  logic             rst_i = 1'b1;
  logic [ADR_W-1:0] prog_adr_i = '0;
  logic [DAT_W-1:0] prog_dat_o;
  logic             core_hold_o;
  logic [7:0]       ld_byte_i = '0;
  logic             ld_valid_i = 1'b0;
  logic             ld_ready_o;
  logic             mem_valid_o;
  logic             load_ok_o;
  logic             load_err_o;
  logic             parity_err_o;

  int checks = 0;
  int errors = 0;

  prog_mem_responder #(.ADR_W(ADR_W), .DAT_W(DAT_W)) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .prog_adr_i  (prog_adr_i),
    .prog_dat_o  (prog_dat_o),
    .core_hold_o (core_hold_o),
    .ld_byte_i   (ld_byte_i),
    .ld_valid_i  (ld_valid_i),
    .ld_ready_o  (ld_ready_o),
    .mem_valid_o (mem_valid_o),
    .load_ok_o   (load_ok_o),
    .load_err_o  (load_err_o),
    .parity_err_o(parity_err_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one byte until it is transferred (bounded wait).
  task automatic send_byte(input logic [7:0] b);
    int   guard;
    logic rdy;
    guard = 0;
    ld_byte_i  = b;
    ld_valid_i = 1'b1;
    do begin
      rdy = ld_ready_o;
      tick();
      guard++;
    end while (!rdy && guard < 20);
    ld_valid_i = 1'b0;
    if (!rdy) begin
      checks++; errors++;
      $display("FAIL send_timeout byte=%h ld_ready stayed 0 for %0d cycles", b, guard);
    end
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    prog_adr_i = 4'h3;
    tick(); tick();
    rst_i = 1'b0;
    tick();
    checks++; if (prog_dat_o !== 14'h0) begin errors++; $display("FAIL reset_dat got=%h exp=0", prog_dat_o); end
    checks++; if (core_hold_o !== 1'b1) begin errors++; $display("FAIL reset_hold got=%b exp=1", core_hold_o); end
    checks++; if (mem_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", mem_valid_o); end
    checks++; if (ld_ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", ld_ready_o); end
    checks++; if (load_ok_o !== 1'b0 || load_err_o !== 1'b0) begin errors++; $display("FAIL reset_pulses ok=%b err=%b exp=0,0", load_ok_o, load_err_o); end
    checks++; if (parity_err_o !== 1'b0) begin errors++; $display("FAIL reset_parity got=%b exp=0", parity_err_o); end
  endtask

  task automatic test_good_frame();
    send_byte(8'hA5); send_byte(8'h02);
    send_byte(8'h34); send_byte(8'h12);
    send_byte(8'hCD); send_byte(8'h2B);
    prog_adr_i = 4'h0;
    send_byte(8'hC0);
    checks++; if (load_ok_o !== 1'b1) begin errors++; $display("FAIL good_ok got=%b exp=1", load_ok_o); end
    checks++; if (core_hold_o !== 1'b0) begin errors++; $display("FAIL good_hold got=%b exp=0", core_hold_o); end
    checks++; if (prog_dat_o !== 14'h0) begin errors++; $display("FAIL good_sum_cycle_fetch got=%h exp=0", prog_dat_o); end
    tick();
    checks++; if (prog_dat_o !== 14'h1234) begin errors++; $display("FAIL good_fetch0 got=%h exp=1234", prog_dat_o); end
    checks++; if (load_ok_o !== 1'b0) begin errors++; $display("FAIL good_ok_width got=%b exp=0", load_ok_o); end
    prog_adr_i = 4'h1;
    tick();
    checks++; if (prog_dat_o !== 14'h2BCD) begin errors++; $display("FAIL good_fetch1 got=%h exp=2bcd", prog_dat_o); end
  endtask

  task automatic test_bad_checksum();
    send_byte(8'hA5); send_byte(8'h02);
    send_byte(8'h34); send_byte(8'h12);
    send_byte(8'hCD); send_byte(8'h2B);
    send_byte(8'h00);
    checks++; if (load_err_o !== 1'b1 || load_ok_o !== 1'b0) begin errors++; $display("FAIL badsum_pulse err=%b ok=%b exp=1,0", load_err_o, load_ok_o); end
    checks++; if (mem_valid_o !== 1'b0) begin errors++; $display("FAIL badsum_valid got=%b exp=0", mem_valid_o); end
    checks++; if (core_hold_o !== 1'b1) begin errors++; $display("FAIL badsum_hold got=%b exp=1", core_hold_o); end
    prog_adr_i = 4'h0;
    tick();
    checks++; if (prog_dat_o !== 14'h0) begin errors++; $display("FAIL badsum_fetch got=%h exp=0", prog_dat_o); end
  endtask

  task automatic test_bad_length();
    send_byte(8'hA5); send_byte(8'h11);
    checks++; if (load_err_o !== 1'b1) begin errors++; $display("FAIL len17_err got=%b exp=1", load_err_o); end
    tick();
    checks++; if (load_err_o !== 1'b0) begin errors++; $display("FAIL len17_err_width got=%b exp=0", load_err_o); end
    send_byte(8'hA5); send_byte(8'h00);
    checks++; if (load_err_o !== 1'b1) begin errors++; $display("FAIL len0_err got=%b exp=1", load_err_o); end
    // Bare sync re-accepted; one-word frame 0x0155, checksum 55^01 = 54.
    send_byte(8'hA5); send_byte(8'h01);
    send_byte(8'h55); send_byte(8'h01);
    send_byte(8'h54);
    checks++; if (load_ok_o !== 1'b1) begin errors++; $display("FAIL resync_ok got=%b exp=1", load_ok_o); end
    prog_adr_i = 4'h0;
    tick();
    checks++; if (prog_dat_o !== 14'h0155) begin errors++; $display("FAIL resync_fetch0 got=%h exp=0155", prog_dat_o); end
    prog_adr_i = 4'h1;
    tick();
    checks++; if (prog_dat_o !== 14'h2BCD) begin errors++; $display("FAIL keep_word1 got=%h exp=2bcd", prog_dat_o); end
  endtask

  task automatic test_back_to_back();
    logic [DAT_W-1:0] exp16 [16];
    logic [7:0] lo, hi, chk;
    chk = 8'h00;
    send_byte(8'hA5); send_byte(8'h10);
    for (int i = 0; i < 16; i++) begin
      lo = 8'(i * 37 + 5);
      hi = 8'(8'hC0 | i);
      exp16[i] = {6'(i), lo};
      chk = chk ^ lo ^ hi;
      repeat ($urandom_range(0, 2)) tick();
      send_byte(lo);
      repeat ($urandom_range(0, 2)) tick();
      send_byte(hi);
      checks++; if (ld_ready_o !== 1'b0) begin errors++; $display("FAIL wr_ready_low word=%0d got=%b exp=0", i, ld_ready_o); end
      tick();
      checks++; if (ld_ready_o !== 1'b1) begin errors++; $display("FAIL wr_ready_back word=%0d got=%b exp=1", i, ld_ready_o); end
    end
    send_byte(chk);
    checks++; if (load_ok_o !== 1'b1) begin errors++; $display("FAIL b2b_ok got=%b exp=1", load_ok_o); end
    for (int i = 0; i <= 16; i++) begin
      prog_adr_i = 4'(i);
      tick();
      checks++; if (prog_dat_o !== exp16[i % 16]) begin errors++; $display("FAIL b2b_fetch step=%0d got=%h exp=%h", i, prog_dat_o, exp16[i % 16]); end
    end
  endtask

  task automatic test_reset_mid_frame();
    send_byte(8'hA5); send_byte(8'h02);
    send_byte(8'h11); send_byte(8'h22);
    tick();
    checks++; if (core_hold_o !== 1'b1 || mem_valid_o !== 1'b0) begin errors++; $display("FAIL midframe_hold hold=%b valid=%b exp=1,0", core_hold_o, mem_valid_o); end
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    checks++; if (mem_valid_o !== 1'b0 || ld_ready_o !== 1'b1) begin errors++; $display("FAIL midrst_state valid=%b ready=%b exp=0,1", mem_valid_o, ld_ready_o); end
    prog_adr_i = 4'h0;
    tick();
    checks++; if (prog_dat_o !== 14'h0) begin errors++; $display("FAIL midrst_fetch got=%h exp=0", prog_dat_o); end
    // Words 0x0777 and 0x3FFF; checksum 77^07^FF^3F = B0.
    send_byte(8'hA5); send_byte(8'h02);
    send_byte(8'h77); send_byte(8'h07);
    send_byte(8'hFF); send_byte(8'h3F);
    send_byte(8'hB0);
    checks++; if (load_ok_o !== 1'b1) begin errors++; $display("FAIL midrst_reload_ok got=%b exp=1", load_ok_o); end
    prog_adr_i = 4'h0;
    tick();
    checks++; if (prog_dat_o !== 14'h0777) begin errors++; $display("FAIL midrst_fetch0 got=%h exp=0777", prog_dat_o); end
    prog_adr_i = 4'h1;
    tick();
    checks++; if (prog_dat_o !== 14'h3FFF) begin errors++; $display("FAIL midrst_fetch1 got=%h exp=3fff", prog_dat_o); end
    checks++; if (parity_err_o !== 1'b0) begin errors++; $display("FAIL parity_clean got=%b exp=0", parity_err_o); end
`ifdef PROG_MEM_PARITY_EN
    dut.par_mem[1] = ~dut.par_mem[1];
    prog_adr_i = 4'h1;
    tick();
    checks++; if (parity_err_o !== 1'b1) begin errors++; $display("FAIL parity_flip got=%b exp=1", parity_err_o); end
`endif
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_bad_checksum();
    test_bad_length();
    test_back_to_back();
    test_reset_mid_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/prog_mem_responder.md
# prog_mem_responder

Program-memory responder for the small instruction-fetch core: accepts the core's next-fetch address, returns the 14-bit instruction word one cycle later, and holds its contents through a byte-serial loader with length and checksum framing. It sits between the core's fetch port (prog_adr_o/prog_dat_i on the core side) and a byte-stream source (UART or debug bridge). While a load is in progress, the core is stalled and fed NOPs.

## Interface
- ADR_W, 4, fetch address width; depth = 2^ADR_W words
- DAT_W, 14, instruction word width; must satisfy 9 ≤ DAT_W ≤ 16
- clk_i  in  1  single clock, rising edge
- rst_i  in  1  synchronous, active-high reset
- prog_adr_i  in  ADR_W  fetch address from core
- prog_dat_o  out  DAT_W  instruction word, registered
- core_hold_o  out  1  stall request to core while loading or memory invalid
- ld_byte_i  in  8  loader byte
- ld_valid_i  in  1  loader byte valid
- ld_ready_o  out  1  responder can accept a byte
- mem_valid_o  out  1  memory holds a checksum-verified image
- load_ok_o  out  1  one-cycle pulse: frame accepted
- load_err_o  out  1  one-cycle pulse: frame rejected
- parity_err_o  out  1  sticky read-parity error (see Configuration)

## Operation
- Byte transfer occurs on any cycle with ld_valid_i & ld_ready_o. ld_byte_i is sampled only on transfer.
- Frame: sync 0xA5, length L, then L words (low byte = word[7:0], high byte = word[DAT_W-1:8], upper unused bits ignored), then checksum = XOR of all 2L data bytes.
- FSM states:
  - SYNC: non-0xA5 bytes are discarded. On 0xA5, go to LEN and clear mem_valid_o.
  - LEN: accepts 1 ≤ L ≤ 2^ADR_W; a byte value of 0 encodes 2^ADR_W only when ADR_W = 8. On an out-of-range L, pulse load_err_o and go to SYNC. Otherwise the word pointer is set to 0 and the FSM goes to LO.
  - LO: latch the low byte, go to HI.
  - HI: latch the high byte, go to WR.
  - WR: ld_ready_o = 0. Write the assembled word to mem[ptr] and increment ptr. Go to LO if ptr < L, otherwise go to SUM. WR lasts exactly one cycle.
  - SUM: on a checksum match, set mem_valid_o and pulse load_ok_o; on a mismatch, pulse load_err_o and leave mem_valid_o = 0. Go to SYNC in both cases.
- Words beyond L keep their previous contents.
- Fetch: prog_dat_o ← mem[prog_adr_i] when mem_valid_o = 1 and FSM is in SYNC; otherwise prog_dat_o ← 0 (NOP).
- core_hold_o = !mem_valid_o | (FSM ≠ SYNC).
- Address wrap is natural modulo 2^ADR_W; there is no out-of-range address.

## Timing
- Reset values:
  - FSM = SYNC, ptr = 0, checksum accumulator = 0
  - prog_dat_o = 0, mem_valid_o = 0, core_hold_o = 1, ld_ready_o = 1
  - load_ok_o = 0, load_err_o = 0, parity_err_o = 0
  - Memory array is not reset.
- Fetch latency: exactly 1 cycle, with no back-pressure on the fetch side.
- ld_ready_o is 1 in every state except WR.
- A full frame of L words takes at least 2 + 3L + 1 cycles.
- load_ok_o and load_err_o pulse in the cycle after the SUM byte is accepted (or after the bad LEN byte). core_hold_o deasserts in the same cycle as load_ok_o.
- A fetch during the SUM-accept cycle still returns 0. The first valid word appears on the cycle after core_hold_o falls.
- rst_i mid-frame: the FSM aborts to SYNC and mem_valid_o = 0. Already-written words remain but are not served until a good frame completes.
- A 0xA5 byte received in LO, HI or SUM is data, not a resync.

## Configuration
- PROG_MEM_PARITY_EN defined:
  - Each word stores an extra even-parity bit computed in WR.
  - Every fetch that returns a memory word (not a forced NOP) checks parity registered alongside prog_dat_o.
  - A mismatch sets parity_err_o, which clears only on rst_i or on load_ok_o.
- PROG_MEM_PARITY_EN undefined: no parity storage, and parity_err_o is tied 0.

## Test plan
- Reset, then fetch address 3 → prog_dat_o = 0, core_hold_o = 1, mem_valid_o = 0.
- Frame A5,02,34,12,CD,2B,checksum=34^12^CD^2B=C0 → load_ok_o pulse. Fetch 0 gives 0x1234 and fetch 1 gives 0x2BCD, one cycle after the address.
- Same frame with checksum 0x00 → load_err_o pulse, mem_valid_o = 0, prog_dat_o = 0, core_hold_o = 1.
- A5,11 (L = 17 with ADR_W = 4) → load_err_o one cycle later. Then a bare A5 is re-accepted as sync.
- ld_valid_i toggled randomly during a 16-word load → ld_ready_o low exactly one cycle after each HI byte. All 16 words are read back correctly, and address F wraps to 0.
- rst_i asserted between two words of a frame → FSM returns to SYNC and mem_valid_o = 0. A following good frame loads correctly. With PROG_MEM_PARITY_EN, forcing a stored parity bit flipped sets parity_err_o on the next fetch of that word.
